fp_fdiv: RTL



---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_fdiv_if.sv | 54 +++++
 rtl/fp_fdiv_step.sv | 18 +
 rtl/fp_fdiv.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP execute-stage constants: fclass bits, extended-format fields,
// biases, divider iteration counts and divider state encoding.
package fp_pkg;

   localparam int CLS_NINF  = 0;
   localparam int CLS_NNORM = 1;
   localparam int CLS_NSUB  = 2;
   localparam int CLS_NZERO = 3;
   localparam int CLS_PZERO = 4;
   localparam int CLS_PSUB  = 5;
   localparam int CLS_PNORM = 6;
   localparam int CLS_PINF  = 7;
   localparam int CLS_SNAN  = 8;
   localparam int CLS_QNAN  = 9;

   localparam int EXT_SIGN    = 64;
   localparam int EXT_EXP_HI  = 63;
   localparam int EXT_EXP_LO  = 52;
   localparam int EXT_FRAC_HI = 51;
   localparam int SGL_FRAC_LO = 29;

   localparam logic [13:0] BIAS_S = 14'd127;
   localparam logic [13:0] BIAS_D = 14'd1023;
   localparam logic [13:0] BIAS_X = 14'd2047;

   localparam logic [5:0] ITER_S = 6'd26;
   localparam logic [5:0] ITER_D = 6'd55;

   localparam logic [1:0] FMT_S = 2'd0;
   localparam logic [1:0] FMT_D = 2'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREP,
      ST_ITER,
      ST_DONE
   } fdiv_state_e;

endpackage

// File: rtl/fp_fdiv_if.sv
// Issue / rounding-bundle handshake between the FP execute stage (master)
// and the iterative divider (slave).
interface fp_fdiv_if;

   logic        fp_fdiv_i_start;
   logic        fp_fdiv_i_kill;
   logic [64:0] fp_fdiv_i_data1;
   logic [64:0] fp_fdiv_i_data2;
   logic [9:0]  fp_fdiv_i_class1;
   logic [9:0]  fp_fdiv_i_class2;
   logic [1:0]  fp_fdiv_i_fmt;
   logic [2:0]  fp_fdiv_i_rm;

   logic        fp_fdiv_o_sig;
   logic [13:0] fp_fdiv_o_expo;
   logic [53:0] fp_fdiv_o_mant;
   logic [1:0]  fp_fdiv_o_rema;
   logic [1:0]  fp_fdiv_o_fmt;
   logic [2:0]  fp_fdiv_o_rm;
   logic [2:0]  fp_fdiv_o_grs;
   logic        fp_fdiv_o_snan;
   logic        fp_fdiv_o_qnan;
   logic        fp_fdiv_o_dbz;
   logic        fp_fdiv_o_infs;
   logic        fp_fdiv_o_zero;
   logic        fp_fdiv_o_diff;
   logic        fp_fdiv_o_ready;
   logic        fp_fdiv_o_busy;

   modport master (
      output fp_fdiv_i_start, fp_fdiv_i_kill,
             fp_fdiv_i_data1, fp_fdiv_i_data2,
             fp_fdiv_i_class1, fp_fdiv_i_class2,
             fp_fdiv_i_fmt, fp_fdiv_i_rm,
      input  fp_fdiv_o_sig, fp_fdiv_o_expo, fp_fdiv_o_mant,
             fp_fdiv_o_rema, fp_fdiv_o_fmt, fp_fdiv_o_rm,
             fp_fdiv_o_grs, fp_fdiv_o_snan, fp_fdiv_o_qnan,
             fp_fdiv_o_dbz, fp_fdiv_o_infs, fp_fdiv_o_zero,
             fp_fdiv_o_diff, fp_fdiv_o_ready, fp_fdiv_o_busy
   );

   modport slave (
      input  fp_fdiv_i_start, fp_fdiv_i_kill,
             fp_fdiv_i_data1, fp_fdiv_i_data2,
             fp_fdiv_i_class1, fp_fdiv_i_class2,
             fp_fdiv_i_fmt, fp_fdiv_i_rm,
      output fp_fdiv_o_sig, fp_fdiv_o_expo, fp_fdiv_o_mant,
             fp_fdiv_o_rema, fp_fdiv_o_fmt, fp_fdiv_o_rm,
             fp_fdiv_o_grs, fp_fdiv_o_snan, fp_fdiv_o_qnan,
             fp_fdiv_o_dbz, fp_fdiv_o_infs, fp_fdiv_o_zero,
             fp_fdiv_o_diff, fp_fdiv_o_ready, fp_fdiv_o_busy
   );

endinterface

// File: rtl/fp_fdiv_step.sv
// One restoring radix-2 division step: compare, conditional subtract, shift.
module fp_fdiv_step (
   input  logic [53:0] rem_i,
   input  logic [52:0] div_i,
   output logic [53:0] rem_o,
   output logic        q_o
);

   logic [52:0] diff;
   logic [52:0] keep;

   // rem < 2*div, so the difference always fits in 53 bits
   assign q_o   = rem_i >= {1'b0, div_i};
   assign diff  = rem_i[52:0] - div_i;
   assign keep  = q_o ? diff : rem_i[52:0];
   assign rem_o = {keep, 1'b0};

endmodule

// File: rtl/fp_fdiv.sv
// Iterative restoring FP divider producing the unrounded bundle for the
// shared rounder; single (26 steps) and double (55 steps).
module fp_fdiv
   import fp_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   fp_fdiv_if.slave  dif
);

   fdiv_state_e state_q;

   logic [64:0] a_q, b_q;
   logic [9:0]  c1_q, c2_q;
   logic [1:0]  fmt_q;
   logic [2:0]  rm_q;
   logic        sig_q;
   logic [52:0] mb_q;
   logic [53:0] rem_q;
   logic [54:0] q_q;
   logic [5:0]  cnt_q;
   logic [13:0] expo_q;
   logic        spec_q;
   logic [4:0]  flg_q;

   logic        r_sig_q, r_ready_q;
   logic [13:0] r_expo_q;
   logic [53:0] r_mant_q;
   logic [2:0]  r_grs_q;
   logic [4:0]  r_flg_q;
   logic [1:0]  r_fmt_q;
   logic [2:0]  r_rm_q;

   logic        dbl;
   logic [52:0] ma_d, mb_d;
   logic        adj_d;
   logic [53:0] rem_d;
   logic [13:0] bias_d, expo_d;
   logic        nan1, nan2, snan1, snan2;
   logic        z1, z2, i1, i2, f1, f2;
   logic [4:0]  flg_d;
   logic        spec_d;
   logic [53:0] mant_fin;
   logic [2:0]  grs_fin;
   logic [53:0] step_rem;
   logic        step_q;

   always_comb begin
      dbl  = (fmt_q == FMT_D);
      ma_d = {1'b1, a_q[EXT_FRAC_HI:0]};
      mb_d = {1'b1, b_q[EXT_FRAC_HI:0]};
      if (!dbl) begin
         ma_d[SGL_FRAC_LO-1:0] = '0;
         mb_d[SGL_FRAC_LO-1:0] = '0;
      end
      adj_d  = ma_d < mb_d;
      rem_d  = adj_d ? {ma_d, 1'b0} : {1'b0, ma_d};
      bias_d = dbl ? BIAS_D : BIAS_S;
      expo_d = ({2'b0, a_q[EXT_EXP_HI:EXT_EXP_LO]} - BIAS_X)
             - ({2'b0, b_q[EXT_EXP_HI:EXT_EXP_LO]} - BIAS_X)
             + bias_d - {13'b0, adj_d};
   end

   always_comb begin
      snan1 = c1_q[CLS_SNAN];
      snan2 = c2_q[CLS_SNAN];
      nan1  = snan1 | c1_q[CLS_QNAN];
      nan2  = snan2 | c2_q[CLS_QNAN];
      z1    = c1_q[CLS_NZERO] | c1_q[CLS_PZERO];
      z2    = c2_q[CLS_NZERO] | c2_q[CLS_PZERO];
      i1    = c1_q[CLS_NINF] | c1_q[CLS_PINF];
      i2    = c2_q[CLS_NINF] | c2_q[CLS_PINF];
      f1    = c1_q[CLS_NNORM] | c1_q[CLS_NSUB]
            | c1_q[CLS_PSUB] | c1_q[CLS_PNORM];
      f2    = c2_q[CLS_NNORM] | c2_q[CLS_NSUB]
            | c2_q[CLS_PSUB] | c2_q[CLS_PNORM];
      // flag order: {snan, qnan, dbz, infs, zero}
      flg_d = '0;
      unique case (1'b1)
         nan1 | nan2:               flg_d = {snan1 | snan2, 4'b1000};
         (z1 & z2) | (i1 & i2):     flg_d = 5'b11000;
         i1 & (f2 | z2):            flg_d = 5'b00010;
         f1 & z2:                   flg_d = 5'b00110;
         (z1 & (f2 | i2)) | (f1 & i2): flg_d = 5'b00001;
         default:                   flg_d = '0;
      endcase
      spec_d = |flg_d;
   end

   always_comb begin
      mant_fin = dbl ? {q_q[54:2], 1'b0} : {q_q[25:2], 30'b0};
      grs_fin  = {q_q[1], q_q[0], |rem_q};
   end

   fp_fdiv_step u_step (
      .rem_i (rem_q),
      .div_i (mb_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q <= '0; b_q <= '0; c1_q <= '0; c2_q <= '0;
         fmt_q <= '0; rm_q <= '0; sig_q <= 1'b0;
         mb_q <= '0; rem_q <= '0; q_q <= '0; cnt_q <= '0;
         expo_q <= '0; spec_q <= 1'b0; flg_q <= '0;
         r_sig_q <= 1'b0; r_ready_q <= 1'b0; r_expo_q <= '0;
         r_mant_q <= '0; r_grs_q <= '0; r_flg_q <= '0;
         r_fmt_q <= '0; r_rm_q <= '0;
      end else if (dif.fp_fdiv_i_kill) begin
         state_q   <= ST_IDLE;
         r_ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               r_ready_q <= 1'b0;
               if (dif.fp_fdiv_i_start) begin
                  a_q     <= dif.fp_fdiv_i_data1;
                  b_q     <= dif.fp_fdiv_i_data2;
                  c1_q    <= dif.fp_fdiv_i_class1;
                  c2_q    <= dif.fp_fdiv_i_class2;
                  fmt_q   <= dif.fp_fdiv_i_fmt;
                  rm_q    <= dif.fp_fdiv_i_rm;
                  state_q <= ST_PREP;
               end
            end
            ST_PREP: begin
               sig_q   <= a_q[EXT_SIGN] ^ b_q[EXT_SIGN];
               mb_q    <= mb_d;
               rem_q   <= rem_d;
               q_q     <= '0;
               expo_q  <= expo_d;
               cnt_q   <= (dbl ? ITER_D : ITER_S) - 6'd1;
               spec_q  <= spec_d;
               flg_q   <= flg_d;
               state_q <= spec_d ? ST_DONE : ST_ITER;
            end
            ST_ITER: begin
               rem_q <= step_rem;
               q_q   <= {q_q[53:0], step_q};
               if (cnt_q == 6'd0) state_q <= ST_DONE;
               else cnt_q <= cnt_q - 6'd1;
            end
            ST_DONE: begin
               r_sig_q   <= sig_q;
               r_expo_q  <= spec_q ? '0 : expo_q;
               r_mant_q  <= spec_q ? '0 : mant_fin;
               r_grs_q   <= spec_q ? '0 : grs_fin;
               r_flg_q   <= flg_q;
               r_fmt_q   <= fmt_q;
               r_rm_q    <= rm_q;
               r_ready_q <= 1'b1;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

   assign dif.fp_fdiv_o_sig   = r_sig_q;
   assign dif.fp_fdiv_o_expo  = r_expo_q;
   assign dif.fp_fdiv_o_mant  = r_mant_q;
   assign dif.fp_fdiv_o_rema  = '0;
   assign dif.fp_fdiv_o_fmt   = r_fmt_q;
   assign dif.fp_fdiv_o_rm    = r_rm_q;
   assign dif.fp_fdiv_o_grs   = r_grs_q;
   assign dif.fp_fdiv_o_snan  = r_flg_q[4];
   assign dif.fp_fdiv_o_qnan  = r_flg_q[3];
   assign dif.fp_fdiv_o_dbz   = r_flg_q[2];
   assign dif.fp_fdiv_o_infs  = r_flg_q[1];
   assign dif.fp_fdiv_o_zero  = r_flg_q[0];
   assign dif.fp_fdiv_o_diff  = 1'b0;
   assign dif.fp_fdiv_o_ready = r_ready_q;
   assign dif.fp_fdiv_o_busy  = (state_q != ST_IDLE);

endmodule
